leve_axir_arb: RTL and testbench
================================

Name: leve_axir_arb

Overview:
- Two-to-one AXI read-channel arbiter. It shares the single external read port between the instruction fetch unit (initiator I) and the data load unit (initiator D).
- One outstanding transaction at a time. AR requests are accepted and registered, re-issued on the target port, and the R channel is routed back to the granted initiator until RLAST.
- A beat counter cross-checks RLAST against ARLEN and flags protocol errors.

Parameters:
- ADDR_W, 64, address width of all AR channels.
- DATA_W, 64, RDATA width.
- LEN_W, 8, ARLEN width.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- I_ARVALID  in  1  instruction initiator AR valid.
- I_ARREADY  out  1  AR accepted from I.
- I_ARADDR  in  ADDR_W  I address.
- I_ARBURST  in  2  I burst type.
- I_ARLEN  in  LEN_W  I burst length minus 1.
- I_RVALID  out  1  R beat valid to I.
- I_RREADY  in  1  I ready for R.
- I_RDATA  out  DATA_W  R data to I.
- I_RLAST  out  1  last beat to I.
- D_*  same set as I_*, for the data initiator.
- M_ARVALID  out  1  target AR valid.
- M_ARREADY  in  1  target AR ready.
- M_ARADDR  out  ADDR_W  registered address.
- M_ARBURST  out  2  registered burst type.
- M_ARLEN  out  LEN_W  registered length.
- M_RVALID  in  1  target R valid.
- M_RREADY  out  1  to target.
- M_RDATA  in  DATA_W  target data.
- M_RLAST  in  1  target last.
- ERR  out  1  sticky protocol error.

Behaviour:
- Reset: state IDLE; all outputs 0 (M_ARVALID, M_ARADDR/BURST/LEN, I/D_ARREADY, I/D_RVALID, M_RREADY, ERR). Internal state resets as: gnt=0, last=D (so I wins the first tie), beat count 0.
- States: IDLE, ACC, ADDR, DATA.
- IDLE:
  - If I_ARVALID or D_ARVALID, choose the winner. If only one is requesting, it wins. If both are requesting, the initiator not equal to `last` wins (round-robin).
  - Latch gnt; go to ACC.
- ACC (1 cycle):
  - Assert the winner's ARREADY combinationally for exactly this cycle; the loser's ARREADY stays 0.
  - Capture the winner's ARADDR/ARBURST/ARLEN into the M_* registers; set M_ARVALID=1 next cycle; go to ADDR.
  - The winner's ARVALID is guaranteed still high, since AXI forbids withdrawal.
- ADDR:
  - Hold M_ARVALID and M_AR* stable until M_ARVALID && M_ARREADY.
  - On that cycle: M_ARVALID<=0, beat count <= 0, go to DATA.
- DATA (combinational routing by gnt):
  - M_RREADY = gnt's RREADY.
  - gnt's RVALID = M_RVALID; RDATA/RLAST pass through.
  - The non-granted initiator sees RVALID=0.
  - RDATA is driven to both initiators; only RVALID is gated.
- DATA beat handling, on each M_RVALID && M_RREADY:
  - beat count +1.
  - If M_RLAST: last<=gnt, go to IDLE. Set ERR if beat count != M_ARLEN.
  - If not M_RLAST and beat count == M_ARLEN (a burst overrun): set ERR and stay in DATA until RLAST arrives.
- Throughput: minimum 3 cycles from ARVALID to M_ARVALID (IDLE, ACC, then ADDR). Back-to-back transactions have 1 idle cycle after RLAST.
- New requests arriving during ACC/ADDR/DATA are held off (ARREADY=0) and arbitrated only in IDLE.
- Beat counter is LEN_W+1 bits; no wrap for ARLEN up to 2^LEN_W-1.
- ERR is sticky; it is cleared only by RST.
- RST asserted mid-transaction: immediate return to reset values. Any in-flight target beats are dropped. The system resets the target simultaneously.
- ARBURST is forwarded unmodified; the arbiter does not interpret it.

Test Plan:
- Single I request, ADDR=0x8000_0000, ARLEN=7, M_ARREADY=1 → I_ARREADY pulses 1 cycle. M_ARVALID appears 2 cycles after I_ARVALID is sampled, with ADDR=0x8000_0000 and LEN=7. 8 beats routed to I; D_RVALID=0 throughout; ERR=0.
- I and D request in the same cycle after reset → I granted first. After I's RLAST, D granted with its address. If both request again, I wins (round-robin alternation holds over 4 transactions).
- M_ARREADY held low for 5 cycles → M_ARVALID/ADDR/LEN stable all 5 cycles; no ARREADY to either initiator.
- Granted initiator RREADY toggled 1-0-1 with M_RVALID=1 → M_RREADY follows it. Data beats are counted only on handshake cycles; all 8 beats are delivered in order.
- ARLEN=3, target asserts RLAST on beat 2 → return to IDLE and ERR=1. Repeat with RLAST on beat 5 → ERR set at beat 4; FSM waits for RLAST.
- RST pulsed during DATA beat 3 → all outputs 0 next edge, state IDLE, ERR=0. A subsequent D request completes normally.

Source files
------------

// File: rtl/leve_axir_arb_if.sv
// One AXI read-address + read-data channel pair, shared by both initiators and the target port.
interface leve_axir_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [1:0]        arburst;
  logic [LEN_W-1:0]  arlen;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;

  modport master (
    output arvalid, araddr, arburst, arlen, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arburst, arlen, rready,
    output arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/leve_axir_arb.sv
// Two-to-one AXI read arbiter: instruction (I) and data (D) initiators share one target read port,
// one transaction in flight, round-robin on ties, sticky RLAST/ARLEN mismatch flag.
module leve_axir_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  leve_axir_arb_if.slave        i_bus,
  leve_axir_arb_if.slave        d_bus,
  leve_axir_arb_if.master       m_bus,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_ADDR, S_DATA} state_e;
  typedef enum logic {INIT_I = 1'b0, INIT_D = 1'b1} init_e;
  typedef logic [LEN_W:0] beat_t;

  state_e            state_q, state_d;
  init_e             gnt_q, gnt_d;
  init_e             last_q, last_d;
  init_e             win;
  logic              m_arvalid_q, m_arvalid_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [1:0]        m_arburst_q, m_arburst_d;
  logic [LEN_W-1:0]  m_arlen_q, m_arlen_d;
  beat_t             beat_q, beat_d;
  logic              err_q, err_d;
  logic              gnt_rready;
  logic              r_hs;
  beat_t             len_ext;

  assign gnt_rready = (gnt_q == INIT_D) ? d_bus.rready : i_bus.rready;
  assign r_hs       = (state_q == S_DATA) && m_bus.rvalid && gnt_rready;
  assign len_ext    = {1'b0, m_arlen_q};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= INIT_I;
      last_q      <= INIT_D;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arburst_q <= '0;
      m_arlen_q   <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arburst_q <= m_arburst_d;
      m_arlen_q   <= m_arlen_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    win = INIT_I;
    if (i_bus.arvalid && d_bus.arvalid) begin
      win = (last_q == INIT_D) ? INIT_I : INIT_D;
    end else if (d_bus.arvalid) begin
      win = INIT_D;
    end
  end

  // NOTE: every next-state signal takes its hold value first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    m_arvalid_d = m_arvalid_q;
    m_araddr_d  = m_araddr_q;
    m_arburst_d = m_arburst_q;
    m_arlen_d   = m_arlen_q;
    beat_d      = beat_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_bus.arvalid || d_bus.arvalid) begin
          gnt_d   = win;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        m_araddr_d  = (gnt_q == INIT_D) ? d_bus.araddr  : i_bus.araddr;
        m_arburst_d = (gnt_q == INIT_D) ? d_bus.arburst : i_bus.arburst;
        m_arlen_d   = (gnt_q == INIT_D) ? d_bus.arlen   : i_bus.arlen;
        m_arvalid_d = 1'b1;
        state_d     = S_ADDR;
      end
      S_ADDR: begin
        if (m_arvalid_q && m_bus.arready) begin
          m_arvalid_d = 1'b0;
          beat_d      = '0;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          beat_d = beat_q + beat_t'(1);
          if (m_bus.rlast) begin
            last_d  = gnt_q;
            state_d = S_IDLE;
            if (beat_q != len_ext) err_d = 1'b1;
          end else if (beat_q == len_ext) begin
            // Overrun: more beats than ARLEN promised; keep draining until RLAST.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_bus.arready = (state_q == S_ACC) && (gnt_q == INIT_I);
    d_bus.arready = (state_q == S_ACC) && (gnt_q == INIT_D);
    i_bus.rvalid  = (state_q == S_DATA) && (gnt_q == INIT_I) && m_bus.rvalid;
    d_bus.rvalid  = (state_q == S_DATA) && (gnt_q == INIT_D) && m_bus.rvalid;
    i_bus.rdata   = m_bus.rdata;
    d_bus.rdata   = m_bus.rdata;
    i_bus.rlast   = m_bus.rlast;
    d_bus.rlast   = m_bus.rlast;
    m_bus.rready  = (state_q == S_DATA) && gnt_rready;
  end

  assign m_bus.arvalid = m_arvalid_q;
  assign m_bus.araddr  = m_araddr_q;
  assign m_bus.arburst = m_arburst_q;
  assign m_bus.arlen   = m_arlen_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_leve_axir_arb.sv
// Directed bench for leve_axir_arb: acts as both initiators and the target, scoreboards read data
// and models the sticky error flag from the handshake count.
module tb_leve_axir_arb;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  always #5 clk = ~clk;

  leve_axir_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) i_bus ();
  leve_axir_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) d_bus ();
  leve_axir_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) m_bus ();

  leve_axir_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus),
    .err_o (err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m_arvalid"}, 64'(m_bus.arvalid), 64'd0);
    check({tag, "_m_araddr"},  m_bus.araddr, 64'd0);
    check({tag, "_m_arlen"},   64'(m_bus.arlen), 64'd0);
    check({tag, "_m_arburst"}, 64'(m_bus.arburst), 64'd0);
    check({tag, "_arready"},   64'(i_bus.arready | d_bus.arready), 64'd0);
    check({tag, "_rvalid"},    64'(i_bus.rvalid | d_bus.rvalid), 64'd0);
    check({tag, "_m_rready"},  64'(m_bus.rready), 64'd0);
    check({tag, "_err"},       64'(err), 64'd0);
  endtask

  // Waits for the grant, then walks ACC and ADDR, optionally stalling the target's ARREADY.
  task automatic address_phase(input logic exp_d, input logic [63:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int stall, input bit exact);
    int n = 0;
    #1;
    while (i_bus.arready !== 1'b1 && d_bus.arready !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("acc_arready_d", 64'(d_bus.arready), 64'(exp_d));
    check("acc_arready_i", 64'(i_bus.arready), 64'(!exp_d));
    if (exact) check("acc_latency", 64'(n), 64'd1);
    check("acc_m_arvalid", 64'(m_bus.arvalid), 64'd0);
    tick();
    if (exp_d) d_bus.arvalid = 1'b0;
    else       i_bus.arvalid = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      m_bus.arready = (s == stall);
      #1;
      check("addr_m_arvalid", 64'(m_bus.arvalid), 64'd1);
      check("addr_m_araddr",  m_bus.araddr, addr);
      check("addr_m_arlen",   64'(m_bus.arlen), 64'(len));
      check("addr_m_arburst", 64'(m_bus.arburst), 64'(burst));
      check("addr_no_arready", 64'(i_bus.arready | d_bus.arready), 64'd0);
      tick();
    end
    m_bus.arready = 1'b0;
    #1;
    check("addr_hs_drop", 64'(m_bus.arvalid), 64'd0);
  endtask

  // Target streams nbeats (RLAST on the final one); abort_at >= 0 pulses reset at that beat.
  task automatic data_phase(input logic to_d, input logic [7:0] len, input int nbeats,
                            input bit toggle, input int abort_at, input logic [63:0] base);
    int   k = 0;
    int   cyc = 0;
    int   pushed = 0;
    logic rr;
    while (k < nbeats && cyc < 200) begin
      if (pushed == k) begin
        exp_q.push_back(base + 64'(k));
        pushed++;
      end
      m_bus.rvalid = 1'b1;
      m_bus.rdata  = base + 64'(k);
      m_bus.rlast  = (k == nbeats - 1);
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      if (to_d) begin d_bus.rready = rr; i_bus.rready = 1'b1; end
      else      begin i_bus.rready = rr; d_bus.rready = 1'b1; end
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check_quiet("mid_rst");
        m_bus.rvalid = 1'b0;
        m_bus.rlast  = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        tick();
        rst = 1'b0;
        return;
      end
      #1;
      check("r_valid_gnt",   64'(to_d ? d_bus.rvalid : i_bus.rvalid), 64'd1);
      check("r_valid_other", 64'(to_d ? i_bus.rvalid : d_bus.rvalid), 64'd0);
      check("r_m_rready",    64'(m_bus.rready), 64'(rr));
      check("r_last",        64'(to_d ? d_bus.rlast : i_bus.rlast), 64'(k == nbeats - 1));
      check("r_err",         64'(err), 64'(exp_err));
      check("r_no_arready",  64'(i_bus.arready | d_bus.arready), 64'd0);
      if (rr) begin
        check("r_data", to_d ? d_bus.rdata : i_bus.rdata, exp_q.pop_front());
        if (k == nbeats - 1) exp_err |= (k != int'(len));
        else                 exp_err |= (k == int'(len));
        k++;
      end
      cyc++;
      tick();
    end
    m_bus.rvalid = 1'b0;
    m_bus.rlast  = 1'b0;
    i_bus.rready = 1'b0;
    d_bus.rready = 1'b0;
    #1;
    check("beats_done", 64'(k), 64'(nbeats));
    check("err_after",  64'(err), 64'(exp_err));
  endtask

  task automatic drive_ar(input logic to_d, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    if (to_d) begin
      d_bus.arvalid = 1'b1; d_bus.araddr = addr; d_bus.arlen = len; d_bus.arburst = burst;
    end else begin
      i_bus.arvalid = 1'b1; i_bus.araddr = addr; i_bus.arlen = len; i_bus.arburst = burst;
    end
  endtask

  initial begin
    i_bus.arvalid = 1'b0; i_bus.araddr = '0; i_bus.arlen = '0; i_bus.arburst = '0; i_bus.rready = 1'b0;
    d_bus.arvalid = 1'b0; d_bus.araddr = '0; d_bus.arlen = '0; d_bus.arburst = '0; d_bus.rready = 1'b0;
    m_bus.arready = 1'b0; m_bus.rvalid = 1'b0; m_bus.rdata = '0; m_bus.rlast = 1'b0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Simultaneous requests alternate I, D, I, D starting with I.
    drive_ar(1'b0, 64'h1000, 8'd1, 2'b10);
    drive_ar(1'b1, 64'h2000, 8'd2, 2'b01);
    address_phase(1'b0, 64'h1000, 8'd1, 2'b10, 0, 1'b1);
    data_phase(1'b0, 8'd1, 2, 1'b0, -1, 64'h1100);
    address_phase(1'b1, 64'h2000, 8'd2, 2'b01, 0, 1'b0);
    data_phase(1'b1, 8'd2, 3, 1'b0, -1, 64'h2200);
    drive_ar(1'b0, 64'h1040, 8'd0, 2'b00);
    drive_ar(1'b1, 64'h2040, 8'd1, 2'b10);
    address_phase(1'b0, 64'h1040, 8'd0, 2'b00, 0, 1'b1);
    data_phase(1'b0, 8'd0, 1, 1'b0, -1, 64'h1300);
    address_phase(1'b1, 64'h2040, 8'd1, 2'b10, 0, 1'b0);
    data_phase(1'b1, 8'd1, 2, 1'b0, -1, 64'h2400);

    drive_ar(1'b0, 64'h8000_0000, 8'd7, 2'b01);
    address_phase(1'b0, 64'h8000_0000, 8'd7, 2'b01, 0, 1'b1);
    data_phase(1'b0, 8'd7, 8, 1'b0, -1, 64'hA000);

    // Target stalls ARREADY five cycles; initiator throttles RREADY.
    drive_ar(1'b0, 64'h4000, 8'd7, 2'b01);
    address_phase(1'b0, 64'h4000, 8'd7, 2'b01, 5, 1'b1);
    data_phase(1'b0, 8'd7, 8, 1'b1, -1, 64'hB000);

    // Early RLAST: three beats against ARLEN=3.
    drive_ar(1'b1, 64'h5000, 8'd3, 2'b01);
    address_phase(1'b1, 64'h5000, 8'd3, 2'b01, 0, 1'b1);
    data_phase(1'b1, 8'd3, 3, 1'b0, -1, 64'hC000);
    check("err_sticky_idle", 64'(err), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 1'b0;
    #1;
    check("err_cleared", 64'(err), 64'd0);
    tick();

    // Overrun: six beats against ARLEN=3.
    drive_ar(1'b0, 64'h5100, 8'd3, 2'b01);
    address_phase(1'b0, 64'h5100, 8'd3, 2'b01, 0, 1'b1);
    data_phase(1'b0, 8'd3, 6, 1'b0, -1, 64'hD000);

    // Reset during beat 3, then a clean D transaction.
    drive_ar(1'b0, 64'h6000, 8'd7, 2'b01);
    address_phase(1'b0, 64'h6000, 8'd7, 2'b01, 0, 1'b1);
    data_phase(1'b0, 8'd7, 8, 1'b0, 3, 64'hE000);
    #1;
    check_quiet("post_rst");
    drive_ar(1'b1, 64'h7000, 8'd4, 2'b10);
    address_phase(1'b1, 64'h7000, 8'd4, 2'b10, 0, 1'b1);
    data_phase(1'b1, 8'd4, 5, 1'b0, -1, 64'hF000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
